chorus_lfo: RTL and testbench



---
 rtl/chorus_pkg.sv | 25 ++
 rtl/lfo_tri_shaper.sv | 27 ++
 rtl/chorus_lfo.sv | 112 +++++++++++
 tb/tb_chorus_lfo.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chorus_pkg.sv
// Shared definitions for the chorus/flanger delay path (DelayBuffer and
// chorus_lfo). Holds the common widths, the delay-line geometry and the
// legal offset window that follows from it.
package chorus_pkg;

  localparam int PKT_WIDTH   = 16;
  localparam int ADDR_WIDTH  = 14;
  localparam int PHASE_WIDTH = 24;

  // Delay-line geometry: nominal delay and total buffer depth in samples.
  localparam int AVG_DELAY = 441;
  localparam int BUF_DEPTH = 4410;

  // Offset window that keeps the read pointer inside the buffer.
  localparam int MIN_OFFSET = -(AVG_DELAY - 1);
  localparam int MAX_OFFSET = BUF_DEPTH - AVG_DELAY - 1;

  // Width of the bipolar triangle sample produced by the shaper.
  localparam int TRI_W = 12;

  typedef logic        [PKT_WIDTH-1:0]   pkt_t;
  typedef logic signed [ADDR_WIDTH-1:0]  offset_t;
  typedef logic        [PHASE_WIDTH-1:0] phase_t;

endpackage

// File: rtl/lfo_tri_shaper.sv
// Combinational phase-to-waveform mapping for the chorus LFO.
// Takes the top TRI_W+1 bits of the phase accumulator and produces a
// bipolar triangle in the range -2^(TRI_W-1) .. 2^(TRI_W-1)-1.
// Ports:
//   phase_msbs - phase[MSB -: TRI_W+1]; MSB selects rising/falling half
//   bipolar    - signed triangle sample
module lfo_tri_shaper
  import chorus_pkg::*;
(
  input  logic        [TRI_W:0]   phase_msbs,
  output logic signed [TRI_W-1:0] bipolar
);

  logic [TRI_W-1:0] ramp;
  logic [TRI_W-1:0] tri_u;

  always_comb begin
    ramp  = phase_msbs[TRI_W-1:0];
    // Second half of the period runs the ramp backwards: (2^TRI_W-1)-ramp
    // is simply the bitwise inverse.
    tri_u = phase_msbs[TRI_W] ? ~ramp : ramp;
    // Subtracting 2^(TRI_W-1) from an unsigned TRI_W-bit value is the same
    // as flipping its MSB and reading it as two's complement.
    bipolar = $signed({~tri_u[TRI_W-1], tri_u[TRI_W-2:0]});
  end

endmodule

// File: rtl/chorus_lfo.sv
// Chorus LFO: per-sample phase accumulator, triangle shaping, depth scaling
// and saturation into the signed extra-delay offset consumed by DelayBuffer.
// Ports:
//   clk                   - system clock
//   rst_n                 - asynchronous active-low reset
//   sampleTick_i          - one-cycle strobe per audio sample
//   enable_i              - 1 = modulate, 0 = phase cleared and offset forced 0
//   rate_i                - unsigned phase increment per tick
//   depth_i               - unsigned peak excursion in samples
//   extraDelay_reg_o      - registered signed offset, held between updates
//   extraDelayValid_reg_o - one-cycle pulse when extraDelay_reg_o updates
// Tick sampled on clock edge k produces the valid pulse after edge k+3.
module chorus_lfo #(
  parameter int PHASE_WIDTH = chorus_pkg::PHASE_WIDTH,
  parameter int ADDR_WIDTH  = chorus_pkg::ADDR_WIDTH,
  parameter int MIN_OFFSET  = chorus_pkg::MIN_OFFSET,
  parameter int MAX_OFFSET  = chorus_pkg::MAX_OFFSET
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sampleTick_i,
  input  logic                         enable_i,
  input  logic        [PHASE_WIDTH-1:0] rate_i,
  input  logic        [ADDR_WIDTH-1:0]  depth_i,
  output logic signed [ADDR_WIDTH-1:0]  extraDelay_reg_o,
  output logic                         extraDelayValid_reg_o
);

  import chorus_pkg::*;

  // Signed triangle times zero-extended depth; wide enough that the
  // product can never overflow.
  localparam int PROD_W = TRI_W + ADDR_WIDTH + 1;

  logic        [PHASE_WIDTH-1:0] phase;
  logic                          vld_p0, vld_p1, vld_p2;
  logic                          en_p0, en_p1, en_p2;
  logic        [ADDR_WIDTH-1:0]  depth_p0, depth_p1;
  logic signed [TRI_W-1:0]       tri_comb, tri_p1;
  logic signed [PROD_W-1:0]      ofs_p2;

  // Scale the triangle by depth and divide by 2^(TRI_W-1), rounding toward
  // minus infinity, so the result spans -depth .. depth-1.
  function automatic logic signed [PROD_W-1:0] scale_floor(
    input logic signed [TRI_W-1:0]      t,
    input logic        [ADDR_WIDTH-1:0] d
  );
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(t) * PROD_W'($signed({1'b0, d}));
    return prod >>> (TRI_W - 1);
  endfunction

  // Saturate into the window the delay line can actually address.
  function automatic logic signed [ADDR_WIDTH-1:0] clamp_ofs(
    input logic signed [PROD_W-1:0] v
  );
    if (v < PROD_W'(MIN_OFFSET))
      return ADDR_WIDTH'(MIN_OFFSET);
    else if (v > PROD_W'(MAX_OFFSET))
      return ADDR_WIDTH'(MAX_OFFSET);
    else
      return v[ADDR_WIDTH-1:0];
  endfunction

  lfo_tri_shaper u_shaper (
    .phase_msbs (phase[PHASE_WIDTH-1 -: TRI_W+1]),
    .bipolar    (tri_comb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase                 <= '0;
      vld_p0                <= 1'b0;
      en_p0                 <= 1'b0;
      depth_p0              <= '0;
      vld_p1                <= 1'b0;
      en_p1                 <= 1'b0;
      depth_p1              <= '0;
      tri_p1                <= '0;
      vld_p2                <= 1'b0;
      en_p2                 <= 1'b0;
      ofs_p2                <= '0;
      extraDelay_reg_o      <= '0;
      extraDelayValid_reg_o <= 1'b0;
    end else begin
      // Stage 0: advance phase and capture controls, on ticks only
      vld_p0 <= sampleTick_i;
      if (sampleTick_i) begin
        phase    <= enable_i ? phase + rate_i : '0;
        en_p0    <= enable_i;
        depth_p0 <= depth_i;
      end

      // Stage 1: triangle from the updated phase
      vld_p1   <= vld_p0;
      en_p1    <= en_p0;
      depth_p1 <= depth_p0;
      tri_p1   <= tri_comb;

      // Stage 2: depth scaling
      vld_p2 <= vld_p1;
      en_p2  <= en_p1;
      ofs_p2 <= scale_floor(tri_p1, depth_p1);

      // Stage 3: saturate, gate by enable, publish
      extraDelayValid_reg_o <= vld_p2;
      if (vld_p2)
        extraDelay_reg_o <= en_p2 ? clamp_ofs(ofs_p2) : '0;
    end
  end

endmodule

// File: tb/tb_chorus_lfo.sv
module tb_chorus_lfo;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tick = 1'b0;
  logic               en = 1'b0;
  logic        [23:0] rate = '0;
  logic        [13:0] depth = '0;
  logic signed [13:0] off;
  logic               vld;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int q_val[$];
  int q_cyc[$];
  logic [23:0] ph_m = '0;

  chorus_lfo dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .sampleTick_i          (tick),
    .enable_i              (en),
    .rate_i                (rate),
    .depth_i               (depth),
    .extraDelay_reg_o      (off),
    .extraDelayValid_reg_o (vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model(input logic [23:0] ph, input int d, input bit e);
    int r, t, b, p, rem, o;
    if (!e) return 0;
    r = int'((ph >> 11) & 24'h000FFF);
    t = ph[23] ? 4095 - r : r;
    b = t - 2048;
    p = b * d;
    rem = ((p % 2048) + 2048) % 2048;
    o = (p - rem) / 2048;
    if (o < -440) o = -440;
    if (o > 3968) o = 3968;
    return o;
  endfunction

  // Drive one tick (called at a negedge) and record the expected result;
  // the DUT samples it on the next posedge, the pulse shows 4 negedges on.
  task automatic tick_push(input logic [23:0] rt, input int d, input bit e);
    rate  = rt;
    depth = 14'(d);
    en    = e;
    tick  = 1'b1;
    ph_m  = e ? ph_m + rt : 24'h0;
    q_val.push_back(model(ph_m, d, e));
    q_cyc.push_back(cyc + 4);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tick = ~tick;
      total++;
      if (off !== 14'sd0 || vld !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: off=%0d vld=%b, want off=0 vld=0", off, vld);
      end
    end
    @(negedge clk);
    tick  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (off !== 14'sd0 || vld !== 1'b0) begin
        bad++;
        $display("FAIL reset_release: off=%0d vld=%b, want off=0 vld=0", off, vld);
      end
    end
  endtask

  task automatic test_static();
    int ev, ec;
    tick_push(24'h0, 100, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (vld) begin
        total++;
        if (q_val.size() == 0) begin
          bad++;
          $display("FAIL static_extra: unexpected pulse off=%0d", off);
        end else begin
          ev = q_val.pop_front();
          ec = q_cyc.pop_front();
          if (off !== 14'(ev) || cyc != ec) begin
            bad++;
            $display("FAIL static: off=%0d cyc=%0d, want off=%0d cyc=%0d", off, cyc, ev, ec);
          end
        end
      end
      @(negedge clk);
    end
    total++;
    if (q_val.size() != 0) begin
      bad++;
      $display("FAIL static_missing: %0d pulses not seen, want 0", q_val.size());
      q_val.delete(); q_cyc.delete();
    end
    repeat (10) @(negedge clk);
    total++;
    if (off !== -14'sd100 || vld !== 1'b0) begin
      bad++;
      $display("FAIL static_hold: off=%0d vld=%b, want off=-100 vld=0", off, vld);
    end
  endtask

  task automatic test_sweep();
    int ev, ec;
    for (int k = 0; k < 4; k++) begin
      tick_push(24'h400000, 100, 1'b1);
      for (int i = 0; i < 4; i++) begin
        if (vld) begin
          total++;
          if (q_val.size() == 0) begin
            bad++;
            $display("FAIL sweep_extra: unexpected pulse off=%0d", off);
          end else begin
            ev = q_val.pop_front();
            ec = q_cyc.pop_front();
            if (off !== 14'(ev) || cyc != ec) begin
              bad++;
              $display("FAIL sweep%0d: off=%0d cyc=%0d, want off=%0d cyc=%0d", k, off, cyc, ev, ec);
            end
          end
        end
        @(negedge clk);
      end
    end
    total++;
    if (q_val.size() != 0) begin
      bad++;
      $display("FAIL sweep_missing: %0d pulses not seen, want 0", q_val.size());
      q_val.delete(); q_cyc.delete();
    end
  endtask

  task automatic test_back_to_back();
    int ev, ec, seen;
    seen = 0;
    for (int k = 0; k < 4; k++) tick_push(24'h400000, 100, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (vld) begin
        total++;
        seen++;
        if (q_val.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: unexpected pulse off=%0d", off);
        end else begin
          ev = q_val.pop_front();
          ec = q_cyc.pop_front();
          if (off !== 14'(ev) || cyc != ec) begin
            bad++;
            $display("FAIL b2b: off=%0d cyc=%0d, want off=%0d cyc=%0d", off, cyc, ev, ec);
          end
        end
      end
      @(negedge clk);
    end
    total++;
    if (seen != 4 || q_val.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: pulses=%0d, want 4", seen);
      q_val.delete(); q_cyc.delete();
    end
  endtask

  task automatic test_clamp();
    int ev, ec;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) tick_push(24'h0, 1000, 1'b1);
      else        tick_push(24'h800000, 5000, 1'b1);
      for (int i = 0; i < 5; i++) begin
        if (vld) begin
          total++;
          if (q_val.size() == 0) begin
            bad++;
            $display("FAIL clamp_extra: unexpected pulse off=%0d", off);
          end else begin
            ev = q_val.pop_front();
            ec = q_cyc.pop_front();
            if (off !== 14'(ev) || cyc != ec) begin
              bad++;
              $display("FAIL clamp%0d: off=%0d cyc=%0d, want off=%0d cyc=%0d", k, off, cyc, ev, ec);
            end
          end
        end
        @(negedge clk);
      end
    end
    total++;
    if (q_val.size() != 0) begin
      bad++;
      $display("FAIL clamp_missing: %0d pulses not seen, want 0", q_val.size());
      q_val.delete(); q_cyc.delete();
    end
  endtask

  task automatic test_enable();
    int ev, ec;
    for (int k = 0; k < 2; k++) begin
      tick_push(24'h400000, 100, (k == 1));
      for (int i = 0; i < 5; i++) begin
        if (vld) begin
          total++;
          if (q_val.size() == 0) begin
            bad++;
            $display("FAIL enable_extra: unexpected pulse off=%0d", off);
          end else begin
            ev = q_val.pop_front();
            ec = q_cyc.pop_front();
            if (off !== 14'(ev) || cyc != ec) begin
              bad++;
              $display("FAIL enable%0d: off=%0d cyc=%0d, want off=%0d cyc=%0d", k, off, cyc, ev, ec);
            end
          end
        end
        @(negedge clk);
      end
    end
    total++;
    if (q_val.size() != 0) begin
      bad++;
      $display("FAIL enable_missing: %0d pulses not seen, want 0", q_val.size());
      q_val.delete(); q_cyc.delete();
    end
  endtask

  task automatic test_reset_mid();
    int ev, ec;
    // Bring the output to a non-zero value first (phase 0x400000 -> 0x800000).
    tick_push(24'h400000, 100, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (q_val.size() == 0 || off !== 14'(q_val[0])) begin
      bad++;
      $display("FAIL mid_pre: off=%0d, want 99", off);
    end
    q_val.delete(); q_cyc.delete();
    // Tick that gets killed in flight.
    rate = 24'h400000; depth = 14'd100; en = 1'b1; tick = 1'b1;
    @(negedge clk);
    tick  = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (off !== 14'sd0 || vld !== 1'b0) begin
      bad++;
      $display("FAIL mid_async: off=%0d vld=%b, want off=0 vld=0", off, vld);
    end
    ph_m = 24'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (off !== 14'sd0 || vld !== 1'b0) begin
        bad++;
        $display("FAIL mid_quiet: off=%0d vld=%b, want off=0 vld=0", off, vld);
      end
    end
    // Restart must begin from phase 0: 0 + 0x800000 -> 99.
    tick_push(24'h800000, 100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (vld) begin
        total++;
        if (q_val.size() == 0) begin
          bad++;
          $display("FAIL mid_extra: unexpected pulse off=%0d", off);
        end else begin
          ev = q_val.pop_front();
          ec = q_cyc.pop_front();
          if (off !== 14'(ev) || cyc != ec) begin
            bad++;
            $display("FAIL mid_restart: off=%0d cyc=%0d, want off=%0d cyc=%0d", off, cyc, ev, ec);
          end
        end
      end
      @(negedge clk);
    end
    total++;
    if (q_val.size() != 0) begin
      bad++;
      $display("FAIL mid_missing: %0d pulses not seen, want 0", q_val.size());
      q_val.delete(); q_cyc.delete();
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_sweep();
    test_back_to_back();
    test_clamp();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, want completion");
    $fatal(1, "timeout");
  end

endmodule
